// File: rtl/lcd_pkg.sv
// -----------------------------------------------------------------------------
// lcd_pkg
// Shared definitions for the LCD drawing blocks: RGB565 colour constants,
// controller command opcodes, the draw_rect state encoding, counter sizing
// and small helpers that build 9-bit command/data bytes for the write engine.
// -----------------------------------------------------------------------------
package lcd_pkg;

  // RGB565 colour constants
  localparam logic [15:0] WHITE  = 16'hFFFF;
  localparam logic [15:0] BLACK  = 16'h0000;
  localparam logic [15:0] BLUE   = 16'h001F;
  localparam logic [15:0] RED    = 16'hF800;
  localparam logic [15:0] GREEN  = 16'h07E0;
  localparam logic [15:0] CYAN   = 16'h07FF;
  localparam logic [15:0] YELLOW = 16'hFFE0;

  // Controller command opcodes
  localparam logic [7:0] CASET = 8'h2A;
  localparam logic [7:0] RASET = 8'h2B;
  localparam logic [7:0] RAMWR = 8'h2C;

  // Window sequence length and byte counter sizing (largest 64x64 rectangle)
  localparam int WIN_BYTES     = 11;
  localparam int MAX_PIX_BYTES = 2 * 64 * 64;
  localparam int CNT_W         = $clog2(MAX_PIX_BYTES + 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CLR_WIN = 3'd1,
    CLR_PIX = 3'd2,
    DRW_WIN = 3'd3,
    DRW_PIX = 3'd4,
    DONE    = 3'd5
  } draw_state_t;

  // bit8 = 0 marks a command byte, 1 marks a data byte
  function automatic logic [8:0] cmd_byte(input logic [7:0] op);
    return {1'b0, op};
  endfunction

  function automatic logic [8:0] data_byte(input logic [7:0] payload);
    return {1'b1, payload};
  endfunction

endpackage

// File: rtl/lcd_window_seq.sv
// -----------------------------------------------------------------------------
// lcd_window_seq
// Walks the 11-byte address-window sequence
//   CASET, xs hi, xs lo, xe hi, xe lo, RASET, ys hi, ys lo, ye hi, ye lo, RAMWR
// under the write engine's wr_done handshake.
//
// Ports
//   sys_clk, sys_rst_n : clock, asynchronous active-low reset
//   start              : restart the sequence at byte 0
//   advance            : the current byte was consumed (wr_done in a window phase)
//   xs, xe, ys, ye     : 16-bit window coordinates
//   next_byte          : byte the parent should register on this edge
//                        (byte 0 on start, otherwise the byte after the current)
//   seq_last           : the current byte is the final RAMWR
// -----------------------------------------------------------------------------
module lcd_window_seq
  import lcd_pkg::*;
(
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        start,
  input  logic        advance,
  input  logic [15:0] xs,
  input  logic [15:0] xe,
  input  logic [15:0] ys,
  input  logic [15:0] ye,
  output logic [8:0]  next_byte,
  output logic        seq_last
);

  localparam logic [3:0] LAST_IDX = 4'(WIN_BYTES - 1);

  logic [3:0] idx;
  logic [3:0] lookup_idx;

  function automatic logic [8:0] win_byte(input logic [3:0] i,
                                          input logic [15:0] x0,
                                          input logic [15:0] x1,
                                          input logic [15:0] y0,
                                          input logic [15:0] y1);
    logic [8:0] b;
    case (i)
      4'd0:    b = cmd_byte(CASET);
      4'd1:    b = data_byte(x0[15:8]);
      4'd2:    b = data_byte(x0[7:0]);
      4'd3:    b = data_byte(x1[15:8]);
      4'd4:    b = data_byte(x1[7:0]);
      4'd5:    b = cmd_byte(RASET);
      4'd6:    b = data_byte(y0[15:8]);
      4'd7:    b = data_byte(y0[7:0]);
      4'd8:    b = data_byte(y1[15:8]);
      4'd9:    b = data_byte(y1[7:0]);
      4'd10:   b = cmd_byte(RAMWR);
      default: b = 9'h000;
    endcase
    return b;
  endfunction

  // Look one byte ahead so the parent can register wr_data on the same edge
  // that consumes the current byte.
  always_comb begin
    lookup_idx = start ? 4'd0 : 4'(idx + 4'd1);
    next_byte  = win_byte(lookup_idx, xs, xe, ys, ye);
    seq_last   = (idx == LAST_IDX);
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      idx <= 4'd0;
    end else if (start) begin
      idx <= 4'd0;
    end else if (advance && (idx != LAST_IDX)) begin
      idx <= 4'(idx + 4'd1);
    end
  end

endmodule

// File: rtl/draw_rect.sv
// -----------------------------------------------------------------------------
// draw_rect
// Moves a fixed-width solid rectangle vertically on an RGB565 panel. On a
// request the previous rectangle (if any, and if the row changed) is painted
// over in BG, then the new one is painted in FG. Bytes are handed to an LCD
// write engine one at a time with a wr_en / wr_done handshake.
//
// Parameters
//   RECT_W, RECT_H : rectangle size in pixels (1..64)
//   X_POS          : fixed start column
//   Y_MAX          : panel row count (requested row is clamped to Y_MAX-RECT_H)
//   FG, BG         : RGB565 draw / clear colours
//
// Ports
//   sys_clk, sys_rst_n : clock, asynchronous active-low reset
//   draw_req, y_coord  : one-cycle move request and requested top row
//   wr_done            : write engine consumed the current byte
//   wr_data, wr_en     : byte to write (bit8 = data/not command) and its valid
//   busy, draw_done    : transfer in progress / one-cycle completion pulse
// -----------------------------------------------------------------------------
module draw_rect
  import lcd_pkg::*;
#(
  parameter int          RECT_W = 8,
  parameter int          RECT_H = 8,
  parameter int          X_POS  = 100,
  parameter int          Y_MAX  = 320,
  parameter logic [15:0] FG     = RED,
  parameter logic [15:0] BG     = WHITE
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       draw_req,
  input  logic [8:0] y_coord,
  input  logic       wr_done,
  output logic [8:0] wr_data,
  output logic       wr_en,
  output logic       busy,
  output logic       draw_done
);

  localparam int               Y_LIM    = Y_MAX - RECT_H;
  localparam logic [CNT_W-1:0] PIX_LAST = CNT_W'(2 * RECT_W * RECT_H - 1);
  localparam logic [15:0]      XS       = 16'(X_POS);
  localparam logic [15:0]      XE       = 16'(X_POS + RECT_W - 1);

  draw_state_t      state;
  logic [8:0]       y_new;
  logic [8:0]       past_y;
  logic             past_valid;
  logic [CNT_W-1:0] cnt;

  logic [8:0]  y_clamp;
  logic        clear_needed;
  logic        pix_last;
  logic [15:0] pix_colour;
  logic        win_start;
  logic        win_advance;
  logic [15:0] win_ys;
  logic [15:0] win_ye;
  logic [8:0]  win_byte;
  logic        win_last;

  // The window generator needs the row of the phase it is about to serve:
  // on acceptance that is past_y (clear) or the clamped request (draw), and
  // the clear->draw handoff restarts it with y_new.
  always_comb begin
    y_clamp      = (32'(y_coord) > 32'(Y_LIM)) ? 9'(Y_LIM) : y_coord;
    clear_needed = past_valid && (y_clamp != past_y);
    pix_last     = (cnt == PIX_LAST);
    pix_colour   = ((state == CLR_WIN) || (state == CLR_PIX)) ? BG : FG;
    win_start    = 1'b0;
    win_ys       = {7'd0, y_new};
    case (state)
      IDLE: begin
        win_start = draw_req;
        win_ys    = clear_needed ? {7'd0, past_y} : {7'd0, y_clamp};
      end
      CLR_WIN: win_ys = {7'd0, past_y};
      CLR_PIX: win_start = wr_done && pix_last;
      default: ;
    endcase
    win_advance = wr_done && ((state == CLR_WIN) || (state == DRW_WIN));
    win_ye      = win_ys + 16'(RECT_H - 1);
  end

  lcd_window_seq u_window_seq (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .start     (win_start),
    .advance   (win_advance),
    .xs        (XS),
    .xe        (XE),
    .ys        (win_ys),
    .ye        (win_ye),
    .next_byte (win_byte),
    .seq_last  (win_last)
  );

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state      <= IDLE;
      wr_data    <= 9'h000;
      wr_en      <= 1'b0;
      busy       <= 1'b0;
      draw_done  <= 1'b0;
      y_new      <= 9'd0;
      past_y     <= 9'd0;
      past_valid <= 1'b0;
      cnt        <= '0;
    end else begin
      draw_done <= 1'b0;
      case (state)
        IDLE: begin
          if (draw_req) begin
            y_new   <= y_clamp;
            busy    <= 1'b1;
            wr_en   <= 1'b1;
            wr_data <= win_byte;
            cnt     <= '0;
            state   <= clear_needed ? CLR_WIN : DRW_WIN;
          end
        end

        CLR_WIN, DRW_WIN: begin
          if (wr_done) begin
            if (win_last) begin
              cnt     <= '0;
              wr_data <= {1'b1, pix_colour[15:8]};
              state   <= (state == CLR_WIN) ? CLR_PIX : DRW_PIX;
            end else begin
              cnt     <= cnt + 1'b1;
              wr_data <= win_byte;
            end
          end
        end

        // Even byte indices carry the colour high byte, odd ones the low byte;
        // cnt still holds the index of the byte being consumed.
        CLR_PIX, DRW_PIX: begin
          if (wr_done) begin
            if (pix_last) begin
              cnt <= '0;
              if (state == CLR_PIX) begin
                wr_data <= win_byte;
                state   <= DRW_WIN;
              end else begin
                wr_en     <= 1'b0;
                wr_data   <= 9'h000;
                draw_done <= 1'b1;
                state     <= DONE;
              end
            end else begin
              cnt     <= cnt + 1'b1;
              wr_data <= cnt[0] ? {1'b1, pix_colour[15:8]}
                                : {1'b1, pix_colour[7:0]};
            end
          end
        end

        DONE: begin
          busy       <= 1'b0;
          past_y     <= y_new;
          past_valid <= 1'b1;
          cnt        <= '0;
          state      <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_draw_rect.sv
// -----------------------------------------------------------------------------
// tb_draw_rect
// Directed bench for draw_rect (4x4 rectangle at column 100). A small model
// queues every byte it expects for each request; the write-engine responder
// pops and compares each byte as the DUT presents it.
// -----------------------------------------------------------------------------
module tb_draw_rect;

  localparam int          W     = 4;
  localparam int          H     = 4;
  localparam int          XP    = 100;
  localparam int          YMAX  = 320;
  localparam logic [15:0] FGC   = 16'hF800;
  localparam logic [15:0] BGC   = 16'hFFFF;

  logic       sys_clk;
  logic       sys_rst_n;
  logic       draw_req;
  logic [8:0] y_coord;
  logic       wr_done;
  logic [8:0] wr_data;
  logic       wr_en;
  logic       busy;
  logic       draw_done;

  logic [8:0] expQ[$];
  int         nAsserts = 0;
  int         nFails   = 0;
  int         mPastY   = 0;
  bit         mPastValid = 1'b0;
  int         expTotal = 0;
  int         reqAt    = -1;
  int         rstAt    = -1;

  draw_rect #(
    .RECT_W (W),
    .RECT_H (H),
    .X_POS  (XP),
    .Y_MAX  (YMAX),
    .FG     (FGC),
    .BG     (BGC)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .draw_req  (draw_req),
    .y_coord   (y_coord),
    .wr_done   (wr_done),
    .wr_data   (wr_data),
    .wr_en     (wr_en),
    .busy      (busy),
    .draw_done (draw_done)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFails++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pushWindow(input int ys);
    int ye;
    int xe;
    ye = ys + H - 1;
    xe = XP + W - 1;
    expQ.push_back(9'h02A);
    expQ.push_back(9'(256 + ((XP >> 8) & 255)));
    expQ.push_back(9'(256 + (XP & 255)));
    expQ.push_back(9'(256 + ((xe >> 8) & 255)));
    expQ.push_back(9'(256 + (xe & 255)));
    expQ.push_back(9'h02B);
    expQ.push_back(9'(256 + ((ys >> 8) & 255)));
    expQ.push_back(9'(256 + (ys & 255)));
    expQ.push_back(9'(256 + ((ye >> 8) & 255)));
    expQ.push_back(9'(256 + (ye & 255)));
    expQ.push_back(9'h02C);
  endtask

  task automatic pushPixels(input logic [15:0] c);
    for (int i = 0; i < W * H; i++) begin
      expQ.push_back({1'b1, c[15:8]});
      expQ.push_back({1'b1, c[7:0]});
    end
  endtask

  // Model the request, then pulse draw_req for one cycle.
  task automatic applyStimulus(input int y);
    int yc;
    yc = (y > YMAX - H) ? (YMAX - H) : y;
    expQ.delete();
    if (mPastValid && (yc != mPastY)) begin
      pushWindow(mPastY);
      pushPixels(BGC);
    end
    pushWindow(yc);
    pushPixels(FGC);
    expTotal   = expQ.size();
    mPastY     = yc;
    mPastValid = 1'b1;
    y_coord  = 9'(y);
    draw_req = 1'b1;
    @(negedge sys_clk);
    draw_req = 1'b0;
    checkEq("busy_on_accept", {31'd0, busy}, 32'd1);
  endtask

  // Act as the write engine until every expected byte is consumed, then check
  // completion. Optionally injects a request or a reset at a given byte.
  task automatic checkOutput(input string name);
    int          served;
    int          guard;
    logic [8:0]  exp;
    bit          wasReset;
    served   = 0;
    wasReset = 1'b0;
    while (expQ.size() > 0) begin
      guard = 0;
      while (!wr_en && guard < 20) begin
        @(negedge sys_clk);
        guard++;
      end
      if (!wr_en) begin
        checkEq({name, "_wr_en_timeout"}, {31'd0, wr_en}, 32'd1);
        expQ.delete();
        break;
      end
      if (served == rstAt) begin
        sys_rst_n = 1'b0;
        #1;
        checkEq({name, "_rst_wr_en"}, {31'd0, wr_en}, 32'd0);
        checkEq({name, "_rst_wr_data"}, {23'd0, wr_data}, 32'd0);
        checkEq({name, "_rst_busy"}, {31'd0, busy}, 32'd0);
        checkEq({name, "_rst_draw_done"}, {31'd0, draw_done}, 32'd0);
        expQ.delete();
        mPastValid = 1'b0;
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        wasReset  = 1'b1;
        break;
      end
      exp = expQ.pop_front();
      checkEq($sformatf("%s_byte%0d", name, served), {23'd0, wr_data}, {23'd0, exp});
      if ($urandom_range(0, 3) == 0) begin
        @(negedge sys_clk);
        checkEq($sformatf("%s_hold%0d", name, served), {22'd0, wr_en, wr_data}, {22'd0, 1'b1, exp});
      end
      if (served == reqAt) begin
        draw_req = 1'b1;
        y_coord  = 9'd10;
      end
      wr_done = 1'b1;
      @(negedge sys_clk);
      wr_done  = 1'b0;
      draw_req = 1'b0;
      served++;
    end
    if (!wasReset) begin
      checkEq({name, "_byte_count"}, 32'(served), 32'(expTotal));
      guard = 0;
      while (!draw_done && guard < 20) begin
        @(negedge sys_clk);
        guard++;
      end
      checkEq({name, "_draw_done"}, {31'd0, draw_done}, 32'd1);
      @(negedge sys_clk);
      checkEq({name, "_done_pulse"}, {31'd0, draw_done}, 32'd0);
      checkEq({name, "_busy_after"}, {31'd0, busy}, 32'd0);
    end
    repeat (3) @(negedge sys_clk);
    checkEq({name, "_idle_wr_en"}, {31'd0, wr_en}, 32'd0);
    checkEq({name, "_idle_busy"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    sys_rst_n = 1'b0;
    draw_req  = 1'b0;
    y_coord   = 9'd0;
    wr_done   = 1'b0;
    repeat (2) @(negedge sys_clk);
    checkEq("reset_wr_en", {31'd0, wr_en}, 32'd0);
    checkEq("reset_wr_data", {23'd0, wr_data}, 32'd0);
    checkEq("reset_busy", {31'd0, busy}, 32'd0);
    checkEq("reset_draw_done", {31'd0, draw_done}, 32'd0);
    sys_rst_n = 1'b1;
    @(negedge sys_clk);

    $display("[TB] first draw y=50");
    applyStimulus(50);
    checkOutput("first");

    $display("[TB] move to y=60");
    applyStimulus(60);
    checkOutput("move60");

    $display("[TB] repeat y=60");
    applyStimulus(60);
    checkOutput("repeat60");

    $display("[TB] clamp y=400");
    applyStimulus(400);
    checkOutput("clamp");

    $display("[TB] request during transfer");
    reqAt = 20;
    applyStimulus(100);
    checkOutput("ignore_req");
    reqAt = -1;

    $display("[TB] reset mid-transfer");
    rstAt = 30;
    applyStimulus(200);
    checkOutput("midreset");
    rstAt = -1;

    $display("[TB] draw after reset y=50");
    applyStimulus(50);
    checkOutput("after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end

endmodule
